// File: rtl/fp_mac_arbiter.sv
// fp_mac_arbiter: round-robin front end that shares one pipelined FP multiply-add unit between two requesters
module fp_mac_arbiter #(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  parameter int NUM_STAGES = 4,
  localparam int W = SIG_WIDTH + EXP_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req0_c,
  input  logic [2:0]   req0_rnd,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [W-1:0] req1_c,
  input  logic [2:0]   req1_rnd,
  input  logic         drain,
  output logic [W-1:0] mac_a,
  output logic [W-1:0] mac_b,
  output logic [W-1:0] mac_c,
  output logic [2:0]   mac_rnd,
  output logic         mac_dg_ctrl,
  input  logic [W-1:0] mac_z,
  input  logic [7:0]   mac_status,
  output logic         resp0_valid,
  output logic         resp1_valid,
  output logic [W-1:0] resp_z,
  output logic [7:0]   resp_status,
  output logic         idle
);
  localparam int CW = $clog2(NUM_STAGES + 1);
  logic                  ptr;
  logic [2:0]            rnd_q;
  logic [NUM_STAGES-1:0] tag_v;
  logic [NUM_STAGES-1:0] tag_id;
  logic [CW-1:0]         cnt;
  logic                  g0;
  logic                  g1;
  logic                  gnt;
  logic                  emerge;
  assign g0 = !rst && !drain && req0_valid && (!ptr || !req1_valid);
  assign g1 = !rst && !drain && req1_valid && (ptr || !req0_valid);
  assign gnt = g0 | g1;
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign mac_a = g0 ? req0_a : g1 ? req1_a : '0;
  assign mac_b = g0 ? req0_b : g1 ? req1_b : '0;
  assign mac_c = g0 ? req0_c : g1 ? req1_c : '0;
  assign mac_dg_ctrl = gnt;
  assign mac_rnd = rst ? 3'd0 : rnd_q;
  assign emerge = !rst && tag_v[NUM_STAGES-1];
  assign resp0_valid = emerge && !tag_id[NUM_STAGES-1];
  assign resp1_valid = emerge && tag_id[NUM_STAGES-1];
  assign resp_z = mac_z;
  assign resp_status = mac_status;
  // the operation retiring this cycle no longer counts as in flight
  assign idle = rst || (!gnt && cnt == CW'(emerge));
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 1'b0;
      rnd_q  <= 3'd0;
      tag_v  <= '0;
      tag_id <= '0;
      cnt    <= '0;
    end else begin
      tag_v  <= {tag_v[NUM_STAGES-2:0], gnt};
      tag_id <= {tag_id[NUM_STAGES-2:0], g1};
      cnt    <= cnt + CW'(gnt) - CW'(emerge);
      if (gnt) begin
        ptr   <= g0;
        rnd_q <= g0 ? req0_rnd : req1_rnd;
      end
    end
  end
endmodule

// File: tb/tb_fp_mac_arbiter.sv
// tb_fp_mac_arbiter: drives four arbiters (NUM_STAGES 2..5) with one stimulus and scores them against a transaction-level model
module tb_fp_mac_arbiter;
  localparam int NI = 4;
  typedef struct { int due; bit id; logic [31:0] z; logic [7:0] st; } ent_t;
  logic clk = 0, rst = 1, drain = 0, r0v = 0, r1v = 0;
  logic [31:0] a0 = 0, b0 = 0, c0 = 0, a1 = 0, b1 = 0, c1 = 0;
  logic [2:0] rnd0 = 0, rnd1 = 0;
  logic rdy0[NI], rdy1[NI], dg[NI], rv0[NI], rv1[NI], idl[NI];
  logic [31:0] ma[NI], mb[NI], mc[NI], rz[NI];
  logic [2:0] mr[NI];
  logic [7:0] rs[NI];
  logic [31:0] zp[NI][5];
  logic [7:0] sp[NI][5];
  int n_chk = 0, n_fail = 0, now = 0;
  int t0s = -100, ts = -100;
  bit m_ptr[NI];
  logic [2:0] m_rnd[NI];
  ent_t q[NI][$];
  int first_cyc[NI] = '{-1, -1, -1, -1};
  logic [31:0] first_z[NI];
  logic [2:0] rnd_seen[NI];
  int rsp_cnt[NI] = '{0, 0, 0, 0};
  bit glog[$];
  int rlog[$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g
    fp_mac_arbiter #(.NUM_STAGES(k + 2)) u (
      .clk(clk), .rst(rst),
      .req0_valid(r0v), .req0_ready(rdy0[k]), .req0_a(a0), .req0_b(b0), .req0_c(c0), .req0_rnd(rnd0),
      .req1_valid(r1v), .req1_ready(rdy1[k]), .req1_a(a1), .req1_b(b1), .req1_c(c1), .req1_rnd(rnd1),
      .drain(drain), .mac_a(ma[k]), .mac_b(mb[k]), .mac_c(mc[k]), .mac_rnd(mr[k]), .mac_dg_ctrl(dg[k]),
      .mac_z(zp[k][k + 1]), .mac_status(sp[k][k + 1]),
      .resp0_valid(rv0[k]), .resp1_valid(rv1[k]), .resp_z(rz[k]), .resp_status(rs[k]), .idle(idl[k]));
  end

  function automatic real f2r(input logic [31:0] x);
    real m;
    int e;
    if (x[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m / 2.0;
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    bit s;
    real m;
    int e;
    s = v < 0.0;
    m = s ? -v : v;
    e = 127;
    if (m == 0.0) return {s, 31'd0};
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [31:0] fma(input logic [31:0] a, b, c);
    return r2f(f2r(a) * f2r(b) + f2r(c));
  endfunction

  function automatic logic [7:0] stat(input logic [31:0] a, c);
    return a[30:23] ^ {c[26:23], c[30:27]} ^ 8'h5A;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ns=%0d cyc=%0d got %h want %h", nm, k + 2, now, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // stand-in MAC: result and status appear NUM_STAGES cycles after the operands
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      for (int s = 4; s > 0; s--) begin
        zp[k][s] <= zp[k][s-1];
        sp[k][s] <= sp[k][s-1];
      end
      zp[k][0] <= dg[k] ? fma(ma[k], mb[k], mc[k]) : 32'hDEADBEEF;
      sp[k][0] <= dg[k] ? stat(ma[k], mc[k]) : 8'hEE;
    end
  end

  always @(negedge clk) begin
    bit e0, e1, hv;
    logic [31:0] ea, eb, ec;
    ent_t hd;
    for (int k = 0; k < NI; k++) begin
      e0 = !rst && !drain && r0v && (!m_ptr[k] || !r1v);
      e1 = !rst && !drain && r1v && (m_ptr[k] || !r0v);
      ea = e0 ? a0 : e1 ? a1 : 32'd0;
      eb = e0 ? b0 : e1 ? b1 : 32'd0;
      ec = e0 ? c0 : e1 ? c1 : 32'd0;
      hv = !rst && q[k].size() > 0 && q[k][0].due == now;
      if (hv) hd = q[k][0];
      chk("ready0", k, 32'(rdy0[k]), 32'(e0));
      chk("ready1", k, 32'(rdy1[k]), 32'(e1));
      chk("dg_ctrl", k, 32'(dg[k]), 32'(e0 | e1));
      chk("mac_a", k, ma[k], ea);
      chk("mac_b", k, mb[k], eb);
      chk("mac_c", k, mc[k], ec);
      chk("mac_rnd", k, 32'(mr[k]), rst ? 32'd0 : 32'(m_rnd[k]));
      chk("resp0", k, 32'(rv0[k]), 32'(hv && !hd.id));
      chk("resp1", k, 32'(rv1[k]), 32'(hv && hd.id));
      if (hv) begin
        chk("resp_z", k, rz[k], hd.z);
        chk("resp_status", k, 32'(rs[k]), 32'(hd.st));
      end
      chk("idle", k, 32'(idl[k]),
          32'(rst || (!(e0 || e1) && (q[k].size() == 0 || q[k][$].due <= now))));
      if (rv0[k] && first_cyc[k] < 0) begin
        first_cyc[k] = now;
        first_z[k] = rz[k];
      end
      if (now == t0s + 1) rnd_seen[k] = mr[k];
      rsp_cnt[k] += int'(rv0[k] | rv1[k]);
      if (k == 2 && now >= ts && now < ts + 6) glog.push_back(rdy1[k]);
      if (k == 2 && now >= ts + 4 && now < ts + 10) rlog.push_back(rv1[k] ? 1 : rv0[k] ? 0 : 3);
      if (rst) begin
        q[k].delete();
        m_ptr[k] = 0;
        m_rnd[k] = 3'd0;
      end else begin
        if (hv) void'(q[k].pop_front());
        if (e0 || e1) begin
          q[k].push_back('{now + k + 2, e1, fma(ea, eb, ec), stat(ea, ec)});
          m_ptr[k] = e0;
          m_rnd[k] = e0 ? rnd0 : rnd1;
        end
      end
    end
    now++;
  end

  initial begin
    int base[NI];
    int td, last, fi;
    rst = 1;
    cyc();
    cyc();
    rst = 0; r0v = 1; a0 = 32'h40000000; b0 = 32'h40400000; c0 = 32'h3F800000; rnd0 = 3'd3;
    t0s = now;
    cyc();
    r0v = 0;
    repeat (8) cyc();
    for (int k = 0; k < NI; k++) begin
      chk("single_z", k, first_z[k], 32'h40E00000);
      chk("single_lat", k, first_cyc[k], t0s + k + 2);
      chk("single_rnd", k, 32'(rnd_seen[k]), 32'd3);
    end
    a1 = 32'h3FC00000; b1 = 32'h40800000; c1 = 32'h3F000000; rnd1 = 3'd1;
    r0v = 1;
    cyc();
    r0v = 0; r1v = 1;
    cyc();
    r1v = 0; r0v = 1;
    cyc();
    r0v = 0; rst = 1;
    for (int k = 0; k < NI; k++) base[k] = rsp_cnt[k];
    cyc();
    rst = 0;
    repeat (12) cyc();
    for (int k = 0; k < NI; k++) chk("rst_no_resp", k, rsp_cnt[k] - base[k], 0);
    chk("rst_cnt", 2, 32'(g[2].u.cnt), 0);
    chk("rst_ptr", 2, 32'(g[2].u.ptr), 0);
    r0v = 1; r1v = 1;
    ts = now;
    repeat (6) cyc();
    r0v = 0; r1v = 0;
    repeat (6) cyc();
    chk("cont_glen", 2, glog.size(), 6);
    chk("cont_rlen", 2, rlog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("cont_grant", 2, 32'(glog[i]), i % 2);
      chk("cont_resp", 2, rlog[i], i % 2);
    end
    r1v = 1;
    repeat (5) cyc();
    drain = 1;
    td = now; last = -1; fi = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) chk("drain_ready", 2, 32'(rdy1[2]), 0);
      if (rv1[2]) last = td + i;
      if (idl[2] && fi < 0) fi = td + i;
      cyc();
    end
    chk("drain_last", 2, last, td + 3);
    chk("drain_idle", 2, fi, td + 3);
    r1v = 0; drain = 0;
    repeat (4) cyc();
    r0v = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("cnt_le", 2, 32'(g[2].u.cnt <= 4), 1);
      if (i == 9) chk("cnt_sat", 2, 32'(g[2].u.cnt), 4);
      cyc();
    end
    r0v = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 3) chk("cnt_last", 2, 32'(g[2].u.cnt), 1);
      if (i == 4) chk("cnt_zero", 2, 32'(g[2].u.cnt), 0);
      cyc();
    end
    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
